// File: rtl/inst_mem_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_pingpong
// Description : Double-buffered instruction memory. An AXI-Stream loader
//               fills the shadow bank while the CPU fetches from the active
//               bank; a swap handshake retargets fetches to the new program.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_pingpong #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ld_TDATA,
    input  logic                  ld_TVALID,
    output logic                  ld_TREADY,
    input  logic                  ld_TLAST,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  cpu_done,
    output logic                  active_bank,
    output logic                  prog_valid,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  overflow
);

    localparam int                  c_mem_words = 2 * (2 ** ADDR_WIDTH);
    localparam logic [0:0]          c_loading   = 1'b0;
    localparam logic [0:0]          c_pending   = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_wp_max  = '1;
    localparam logic [ADDR_WIDTH:0] c_len_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_len_zero  = '0;

    // Bank bit is the address MSB: {bank, offset}
    logic [DATA_WIDTH-1:0] r_mem [0:c_mem_words-1];

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH:0]   r_shadow_len;
    logic                  r_active_bank;
    logic                  r_prog_valid;
    logic [ADDR_WIDTH:0]   r_prog_len;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_accept;
    logic                  w_at_end;
    logic                  w_last_beat;
    logic                  w_overflow_hit;
    logic                  w_swap;
    logic [ADDR_WIDTH:0]   w_wp_plus_one;

    // Load FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_loading;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Load FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_loading: if (w_last_beat) w_state_next = c_pending;
            c_pending: if (w_swap)      w_state_next = c_loading;
            default:                    w_state_next = c_loading;
        endcase
    end

    // Load FSM outputs: beat acceptance, end-of-program and swap strobes
    always_comb begin
        w_accept       = ld_TVALID & r_ready & (r_state == c_loading);
        w_at_end       = (r_wp == c_wp_max);
        w_last_beat    = w_accept & (ld_TLAST | w_at_end);
        w_overflow_hit = w_accept & ~ld_TLAST & w_at_end;
        w_swap         = (r_state == c_pending) & (cpu_done | ~r_prog_valid);
        w_wp_plus_one  = {1'b0, r_wp} + c_len_one;
    end

    // TREADY is registered so it stays low while reset is held and rises on
    // the first edge afterwards; it tracks the state the FSM is entering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_state_next == c_loading);
        end
    end

    // Write pointer, shadow length, bank selection and program status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp          <= '0;
            r_shadow_len  <= c_len_zero;
            r_active_bank <= 1'b0;
            r_prog_valid  <= 1'b0;
            r_prog_len    <= c_len_zero;
            r_overflow    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_last_beat) begin
                // wp+1 equals DEPTH at the last slot, covering both TLAST
                // and forced-termination cases
                r_shadow_len <= w_wp_plus_one;
            end
            if (w_overflow_hit) begin
                r_overflow <= 1'b1;
            end
            if (w_swap) begin
                r_active_bank <= ~r_active_bank;
                r_prog_valid  <= 1'b1;
                r_prog_len    <= r_shadow_len;
                r_wp          <= '0;
            end
        end
    end

    // Loader write port: always into the bank the CPU is not fetching from
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{~r_active_bank, r_wp}] <= ld_TDATA;
        end
    end

    // CPU read port: one-cycle latency, holds when not enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[{r_active_bank, rd_addr}];
        end
    end

    assign ld_TREADY   = r_ready;
    assign rd_data     = r_rd_data;
    assign active_bank = r_active_bank;
    assign prog_valid  = r_prog_valid;
    assign prog_len    = r_prog_len;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_pingpong
// Description : Directed table-driven bench for inst_mem_pingpong (8-deep
//               banks) plus a hand-written asynchronous reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_pingpong;

    localparam int AW = 3;
    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] ld_TDATA;
    logic          ld_TVALID;
    logic          ld_TREADY;
    logic          ld_TLAST;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          cpu_done;
    logic          active_bank;
    logic          prog_valid;
    logic [AW:0]   prog_len;
    logic          overflow;

    inst_mem_pingpong #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_TDATA   (ld_TDATA),
        .ld_TVALID  (ld_TVALID),
        .ld_TREADY  (ld_TREADY),
        .ld_TLAST   (ld_TLAST),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .cpu_done   (cpu_done),
        .active_bank(active_bank),
        .prog_valid (prog_valid),
        .prog_len   (prog_len),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          re;
        logic [AW-1:0] ra;
        logic          done;
        logic          e_rdy;
        logic          e_ab;
        logic          e_pv;
        logic [AW:0]   e_len;
        logic          e_ovf;
        logic          c_rd;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;
    int   step;

    function automatic logic [DW-1:0] w(input logic [7:0] tag, input int i);
        logic [7:0] lo;
        lo = i[7:0];
        return {tag, 48'h0, lo};
    endfunction

    function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic l,
                                input logic re, input logic [AW-1:0] ra, input logic done,
                                input logic e_rdy, input logic e_ab, input logic e_pv,
                                input logic [AW:0] e_len, input logic e_ovf,
                                input logic c_rd, input logic [DW-1:0] e_rd);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.re = re; t.ra = ra; t.done = done;
        t.e_rdy = e_rdy; t.e_ab = e_ab; t.e_pv = e_pv; t.e_len = e_len;
        t.e_ovf = e_ovf; t.c_rd = c_rd; t.e_rd = e_rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic chk_status(input logic e_rdy, input logic e_ab, input logic e_pv,
                              input logic [AW:0] e_len, input logic e_ovf);
        chk("ld_TREADY",   {63'h0, ld_TREADY},   {63'h0, e_rdy});
        chk("active_bank", {63'h0, active_bank}, {63'h0, e_ab});
        chk("prog_valid",  {63'h0, prog_valid},  {63'h0, e_pv});
        chk("prog_len",    {60'h0, prog_len},    {60'h0, e_len});
        chk("overflow",    {63'h0, overflow},    {63'h0, e_ovf});
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic re, input logic [AW-1:0] ra, input logic done);
        ld_TVALID = v; ld_TDATA = d; ld_TLAST = l;
        rd_en = re; rd_addr = ra; cpu_done = done;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        step  = 0;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        //          v  data        l  re ra done | rdy ab pv len ovf crd rd
        // Program A (4 beats) into bank 1, auto-activated
        vecs.push_back(mk(1, w(8'hA0,0), 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, '0));
        vecs.push_back(mk(1, w(8'hA0,1), 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, '0));
        vecs.push_back(mk(1, w(8'hA0,2), 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, '0));
        vecs.push_back(mk(1, w(8'hA0,3), 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, '0));
        vecs.push_back(mk(0, '0,         0, 0, 0, 0,  1, 1, 1, 4, 0, 0, '0));
        vecs.push_back(mk(0, '0,         0, 1, 2, 0,  1, 1, 1, 4, 0, 1, w(8'hA0,2)));
        // Program B (3 beats) into bank 0 while fetching A
        vecs.push_back(mk(1, w(8'hB0,0), 0, 1, 0, 0,  1, 1, 1, 4, 0, 1, w(8'hA0,0)));
        vecs.push_back(mk(1, w(8'hB0,1), 0, 1, 3, 0,  1, 1, 1, 4, 0, 1, w(8'hA0,3)));
        vecs.push_back(mk(1, w(8'hB0,2), 1, 1, 1, 0,  0, 1, 1, 4, 0, 1, w(8'hA0,1)));
        vecs.push_back(mk(0, '0,         0, 1, 2, 0,  0, 1, 1, 4, 0, 1, w(8'hA0,2)));
        // Swap with a fetch at the same edge: data from old bank
        vecs.push_back(mk(0, '0,         0, 1, 0, 1,  1, 0, 1, 3, 0, 1, w(8'hA0,0)));
        vecs.push_back(mk(0, '0,         0, 1, 0, 0,  1, 0, 1, 3, 0, 1, w(8'hB0,0)));
        vecs.push_back(mk(0, '0,         0, 1, 2, 0,  1, 0, 1, 3, 0, 1, w(8'hB0,2)));
        // Program C with cpu_done pulsed mid-load (ignored)
        vecs.push_back(mk(1, w(8'hC0,0), 0, 0, 0, 0,  1, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(1, w(8'hC0,1), 0, 0, 0, 1,  1, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(1, w(8'hC0,2), 1, 0, 0, 0,  0, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(0, '0,         0, 0, 0, 0,  0, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(0, '0,         0, 0, 0, 0,  0, 0, 1, 3, 0, 0, '0));
        vecs.push_back(mk(0, '0,         0, 0, 0, 1,  1, 1, 1, 3, 0, 0, '0));
        vecs.push_back(mk(0, '0,         0, 1, 1, 0,  1, 1, 1, 3, 0, 1, w(8'hC0,1)));
        // rd_en low: rd_data holds
        vecs.push_back(mk(0, '0,         0, 0, 0, 0,  1, 1, 1, 3, 0, 1, w(8'hC0,1)));
        // Program D: 8 beats without TLAST -> overflow
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1, w(8'hD0,i), 0, 0, 0, 0, 1, 1, 1, 3, 0, 0, '0));
        vecs.push_back(mk(1, w(8'hD0,7), 0, 0, 0, 0,  0, 1, 1, 3, 1, 0, '0));
        vecs.push_back(mk(0, '0,         0, 0, 0, 0,  0, 1, 1, 3, 1, 0, '0));
        vecs.push_back(mk(0, '0,         0, 0, 0, 1,  1, 0, 1, 8, 1, 0, '0));
        vecs.push_back(mk(0, '0,         0, 1, 7, 0,  1, 0, 1, 8, 1, 1, w(8'hD0,7)));
        vecs.push_back(mk(0, '0,         0, 1, 0, 0,  1, 0, 1, 8, 1, 1, w(8'hD0,0)));

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        chk_status(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("rd_data_reset", rd_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tready_before_edge", {63'h0, ld_TREADY}, 64'h0);
        @(posedge clk);
        #1;
        chk("tready_after_release", {63'h0, ld_TREADY}, 64'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            step = i + 1;
            @(negedge clk);
            drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].re, vecs[i].ra, vecs[i].done);
            @(posedge clk);
            #1;
            chk_status(vecs[i].e_rdy, vecs[i].e_ab, vecs[i].e_pv, vecs[i].e_len, vecs[i].e_ovf);
            if (vecs[i].c_rd) chk("rd_data", rd_data, vecs[i].e_rd);
        end

        // Asynchronous reset after 2 of 5 load beats
        step = 1000;
        @(negedge clk);
        drive(1'b1, w(8'hE0,0), 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        drive(1'b1, w(8'hE0,1), 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk_status(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("rd_data_async_reset", rd_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step = 1001;
        chk_status(1'b1, 1'b0, 1'b0, '0, 1'b0);
        // Fresh 1-beat program auto-activates
        @(negedge clk);
        drive(1'b1, w(8'hF0,0), 1'b1, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        step = 1002;
        chk_status(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        step = 1003;
        chk_status(1'b1, 1'b1, 1'b1, 4'd1, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
        @(posedge clk);
        #1;
        step = 1004;
        chk("rd_data_fresh", rd_data, w(8'hF0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
